proc_stage_ctrl: RTL and testbench

Top-level sequencer for the 128x128 image pipeline: denoise (stage 0), threshold (stage 1), edge detect (stage 2).
- Launches the three stages strictly in order and clears them before each run.
- Multiplexes the single shared image SRAM port to whichever stage is active.
- Latches per-run configuration, including the black/white polarity flag for the threshold stage.
- Guards each stage with a watchdog.

---
 rtl/proc_stage_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_proc_stage_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_stage_ctrl.sv
// proc_stage_ctrl: run sequencer for the denoise -> threshold -> edge image pipeline.
//   Clears the stages, launches them strictly in order, muxes the shared SRAM port to
//   whichever stage is active, latches per-run polarity and guards each stage with a watchdog.
// Ports:
//   clk, reset (async, active-high); start/cfg_wb run request + polarity config;
//   busy/all_done/err/illegal_acc status; stg_rst/wb_flag/sN_en stage control;
//   sN_done/sN_rd/sN_wr/sN_addr/sN_wdata per-stage inputs; mem_* shared SRAM port.
module proc_stage_ctrl #(
  parameter int                ADDR_W   = 14,
  parameter int                DATA_W   = 8,
  parameter int                WDOG_W   = 20,
  parameter logic [WDOG_W-1:0] WDOG_MAX = 20'd200000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_wb,
  output logic              busy,
  output logic              all_done,
  output logic              err,
  output logic              illegal_acc,
  output logic              stg_rst,
  output logic              wb_flag,
  output logic              s0_en,
  output logic              s1_en,
  output logic              s2_en,
  input  logic              s0_done,
  input  logic              s1_done,
  input  logic              s2_done,
  input  logic              s0_rd,
  input  logic              s0_wr,
  input  logic              s1_rd,
  input  logic              s1_wr,
  input  logic              s2_rd,
  input  logic              s2_wr,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [ADDR_W-1:0] s2_addr,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic              s1_wdata,
  input  logic [DATA_W-1:0] s2_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN0,
    ST_RUN1,
    ST_RUN2,
    ST_DONE,
    ST_ERR
  } state_t;

  // Last cycle a stage may run without done; entering ERR here means the counter never wraps.
  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_MAX - 1'b1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WDOG_W-1:0] r_wdog;
  logic              r_busy;
  logic              r_wb;
  logic              r_ill;

  logic              w_run;
  logic              w_start_acc;
  logic              w_act_done;
  logic              w_wdog_hit;
  logic              w_act_rd;
  logic              w_act_wr;
  logic              w_viol;
  logic [2:0]        w_en;
  logic [2:0]        w_req;

  assign w_run       = (r_state == ST_RUN0) || (r_state == ST_RUN1) || (r_state == ST_RUN2);
  // start is only honoured when no run is in flight.
  assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_ERR));
  assign w_wdog_hit  = (r_wdog == WDOG_LIM);

  assign w_en  = {r_state == ST_RUN2, r_state == ST_RUN1, r_state == ST_RUN0};
  assign w_req = {s2_rd | s2_wr, s1_rd | s1_wr, s0_rd | s0_wr};

  // Next-state logic. Done is sampled as a level: the CLR pulse wipes stale done beforehand.
  always_comb begin
    w_state_nxt = r_state;
    w_act_done  = 1'b0;
    case (r_state)
      ST_RUN0: w_act_done = s0_done;
      ST_RUN1: w_act_done = s1_done;
      ST_RUN2: w_act_done = s2_done;
      default: w_act_done = 1'b0;
    endcase
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_CLR;
      ST_CLR:  w_state_nxt = ST_RUN0;
      // done is checked before the watchdog so a same-cycle done still advances.
      ST_RUN0: if (s0_done) w_state_nxt = ST_RUN1; else if (w_wdog_hit) w_state_nxt = ST_ERR;
      ST_RUN1: if (s1_done) w_state_nxt = ST_RUN2; else if (w_wdog_hit) w_state_nxt = ST_ERR;
      ST_RUN2: if (s2_done) w_state_nxt = ST_DONE; else if (w_wdog_hit) w_state_nxt = ST_ERR;
      ST_DONE: w_state_nxt = ST_IDLE;
      ST_ERR:  if (start) w_state_nxt = ST_CLR;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Watchdog counts cycles spent in the current stage; zeroed on every stage change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog <= '0;
    end else if (w_run && !w_act_done && !w_wdog_hit) begin
      r_wdog <= r_wdog + 1'b1;
    end else begin
      r_wdog <= '0;
    end
  end

  // busy tracks the state being entered, so it rises the cycle after start is accepted
  // and is already low in the first IDLE or ERR cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_ERR);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb  <= 1'b0;
      r_ill <= 1'b0;
    end else if (w_start_acc) begin
      r_wb  <= cfg_wb;
      r_ill <= 1'b0;
    end else if (w_viol) begin
      r_ill <= 1'b1;
    end
  end

  // Shared SRAM mux, decoded from the registered state so it adds no latency.
  always_comb begin
    w_act_rd  = 1'b0;
    w_act_wr  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      ST_RUN0: begin
        w_act_rd  = s0_rd;
        w_act_wr  = s0_wr;
        mem_addr  = s0_addr;
        mem_wdata = s0_wdata;
      end
      ST_RUN1: begin
        w_act_rd  = s1_rd;
        w_act_wr  = s1_wr;
        mem_addr  = s1_addr;
        // Threshold stage produces one bit per pixel; expand to full black/white.
        mem_wdata = {DATA_W{s1_wdata}};
      end
      ST_RUN2: begin
        w_act_rd  = s2_rd;
        w_act_wr  = s2_wr;
        mem_addr  = s2_addr;
        mem_wdata = s2_wdata;
      end
      default: begin
        w_act_rd  = 1'b0;
        w_act_wr  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
      end
    endcase
  end

  // A read colliding with a write from the active stage is dropped; the write proceeds.
  assign mem_wr = w_act_wr;
  assign mem_rd = w_act_rd && !w_act_wr;

  // Violations: an idle stage requesting the port, or rd+wr together from the active stage.
  assign w_viol = w_run && ((|(w_req & ~w_en)) || (w_act_rd && w_act_wr));

  assign busy        = r_busy;
  assign all_done    = (r_state == ST_DONE);
  assign err         = (r_state == ST_ERR);   // sticky: only start or reset leaves ERR
  assign illegal_acc = r_ill;
  assign stg_rst     = (r_state == ST_CLR);
  assign wb_flag     = r_wb;
  assign s0_en       = w_en[0];
  assign s1_en       = w_en[1];
  assign s2_en       = w_en[2];

endmodule

// File: tb/tb_proc_stage_ctrl.sv
module tb_proc_stage_ctrl;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Shared stimulus
  logic start, cfg_wb;
  logic s0_rd, s0_wr, s1_rd, s1_wr, s2_rd, s2_wr;
  logic [ADDR_W-1:0] s0_addr, s1_addr, s2_addr;
  logic [DATA_W-1:0] s0_wdata, s2_wdata;
  logic s1_wdata;

  // Main DUT (default watchdog)
  logic s0_done, s1_done, s2_done;
  logic busy, all_done, err, illegal_acc, stg_rst, wb_flag, s0_en, s1_en, s2_en;
  logic mem_rd, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Watchdog DUT (WDOG_MAX = 100)
  logic start_w, wd_s0_done, wd_s1_done, wd_s2_done;
  logic wd_busy, wd_all_done, wd_err, wd_ill, wd_stg_rst, wd_wb, wd_s0_en, wd_s1_en, wd_s2_en;
  logic wd_mem_rd, wd_mem_wr;
  logic [ADDR_W-1:0] wd_mem_addr;
  logic [DATA_W-1:0] wd_mem_wdata;

  proc_stage_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .cfg_wb(cfg_wb),
    .busy(busy), .all_done(all_done), .err(err), .illegal_acc(illegal_acc),
    .stg_rst(stg_rst), .wb_flag(wb_flag), .s0_en(s0_en), .s1_en(s1_en), .s2_en(s2_en),
    .s0_done(s0_done), .s1_done(s1_done), .s2_done(s2_done),
    .s0_rd(s0_rd), .s0_wr(s0_wr), .s1_rd(s1_rd), .s1_wr(s1_wr), .s2_rd(s2_rd), .s2_wr(s2_wr),
    .s0_addr(s0_addr), .s1_addr(s1_addr), .s2_addr(s2_addr),
    .s0_wdata(s0_wdata), .s1_wdata(s1_wdata), .s2_wdata(s2_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  proc_stage_ctrl #(.WDOG_MAX(20'd100)) u_dut_wd (
    .clk(clk), .reset(reset), .start(start_w), .cfg_wb(cfg_wb),
    .busy(wd_busy), .all_done(wd_all_done), .err(wd_err), .illegal_acc(wd_ill),
    .stg_rst(wd_stg_rst), .wb_flag(wd_wb), .s0_en(wd_s0_en), .s1_en(wd_s1_en), .s2_en(wd_s2_en),
    .s0_done(wd_s0_done), .s1_done(wd_s1_done), .s2_done(wd_s2_done),
    .s0_rd(s0_rd), .s0_wr(s0_wr), .s1_rd(s1_rd), .s1_wr(s1_wr), .s2_rd(s2_rd), .s2_wr(s2_wr),
    .s0_addr(s0_addr), .s1_addr(s1_addr), .s2_addr(s2_addr),
    .s0_wdata(s0_wdata), .s1_wdata(s1_wdata), .s2_wdata(s2_wdata),
    .mem_rd(wd_mem_rd), .mem_wr(wd_mem_wr), .mem_addr(wd_mem_addr), .mem_wdata(wd_mem_wdata)
  );

  // Stage models for the main DUT: done rises once the stage has been enabled d_lim cycles.
  int d_lim [3];
  int en_cnt [3];
  assign s0_done = (en_cnt[0] >= d_lim[0]);
  assign s1_done = (en_cnt[1] >= d_lim[1]);
  assign s2_done = (en_cnt[2] >= d_lim[2]);
  always @(posedge clk or posedge reset) begin
    if (reset || stg_rst) begin
      en_cnt[0] <= 0; en_cnt[1] <= 0; en_cnt[2] <= 0;
    end else begin
      if (s0_en) en_cnt[0] <= en_cnt[0] + 1;
      if (s1_en) en_cnt[1] <= en_cnt[1] + 1;
      if (s2_en) en_cnt[2] <= en_cnt[2] + 1;
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  // Model of the run-to-run sticky state of the main DUT
  logic m_wb, m_err, m_ill;

  function automatic logic [32:0] obs_main();
    return {busy, all_done, err, illegal_acc, stg_rst, wb_flag, s0_en, s1_en, s2_en,
            mem_rd, mem_wr, mem_addr, mem_wdata};
  endfunction

  function automatic logic [32:0] obs_wd();
    return {wd_busy, wd_all_done, wd_err, wd_ill, wd_stg_rst, wd_wb, wd_s0_en, wd_s1_en,
            wd_s2_en, wd_mem_rd, wd_mem_wr, wd_mem_addr, wd_mem_wdata};
  endfunction

  task automatic clear_traffic();
    s0_rd = 0; s0_wr = 0; s1_rd = 0; s1_wr = 0; s2_rd = 0; s2_wr = 0;
    s0_addr = '0; s1_addr = '0; s2_addr = '0;
    s0_wdata = '0; s1_wdata = 0; s2_wdata = '0;
  endtask

  // Full run checked cycle by cycle against a timeline computed from the stage lengths.
  // Cycle 0 = start driven in IDLE, 1 = clear pulse, then each stage lasts d+1 cycles.
  task automatic run_sequence(input int d0, input int d1, input int d2, input bit wb,
                              input bit inj);
    int l0, l1, l2, c_done, inj_c, a, kind, nf;
    logic [32:0] exp_v, got_v;
    logic e_busy, e_ad, e_err, e_ill, e_rst, e_wb, e_rd, e_wr;
    logic [2:0] e_en;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    l0 = d0 + 1; l1 = d1 + 1; l2 = d2 + 1;
    c_done = 2 + l0 + l1 + l2;
    inj_c = 2 + l0 + l1 / 2;
    d_lim[0] = d0; d_lim[1] = d1; d_lim[2] = d2;
    nf = 0;
    for (int c = 0; c <= c_done + 1; c++) begin
      @(posedge clk); #1;
      start  = (c == 0) || (inj && c == inj_c);
      cfg_wb = (c == 0) ? wb : (inj && c == inj_c) ? ~wb : 1'($urandom);
      a = -1;
      if (c >= 2 && c < 2 + l0) a = 0;
      else if (c >= 2 + l0 && c < 2 + l0 + l1) a = 1;
      else if (c >= 2 + l0 + l1 && c < c_done) a = 2;
      kind = $urandom_range(0, 2);
      s0_addr = 14'($urandom); s1_addr = 14'($urandom); s2_addr = 14'($urandom);
      s0_wdata = 8'($urandom); s2_wdata = 8'($urandom); s1_wdata = 1'($urandom);
      s0_rd = (a == 0 && kind == 1); s0_wr = (a == 0 && kind == 2);
      s1_rd = (a == 1 && kind == 1); s1_wr = (a == 1 && kind == 2);
      s2_rd = (a == 2 && kind == 1); s2_wr = (a == 2 && kind == 2);
      e_busy = (c >= 1 && c <= c_done);
      e_ad   = (c == c_done);
      e_err  = (c == 0) ? m_err : 1'b0;
      e_ill  = (c == 0) ? m_ill : 1'b0;
      e_rst  = (c == 1);
      e_wb   = (c == 0) ? m_wb : wb;
      e_en   = '0;
      e_rd = 0; e_wr = 0; e_addr = '0; e_data = '0;
      if (a >= 0) begin
        e_en[a] = 1'b1;
        e_rd = (kind == 1);
        e_wr = (kind == 2);
        e_addr = (a == 0) ? s0_addr : (a == 1) ? s1_addr : s2_addr;
        e_data = (a == 0) ? s0_wdata : (a == 1) ? (s1_wdata ? 8'hFF : 8'h00) : s2_wdata;
      end
      exp_v = {e_busy, e_ad, e_err, e_ill, e_rst, e_wb, e_en[0], e_en[1], e_en[2],
               e_rd, e_wr, e_addr, e_data};
      #3;
      got_v = obs_main();
      n_chk++;
      if (got_v !== exp_v) begin
        $display("FAIL seq_cycle c=%0d got=%h exp=%h", c, got_v, exp_v);
        nf++;
        if (nf >= 10) break;
      end else n_pass++;
    end
    start = 0;
    clear_traffic();
    m_wb = wb; m_err = 0; m_ill = 0;
  endtask

  task automatic test_reset();
    reset = 1; start = 0; start_w = 0; cfg_wb = 0;
    wd_s0_done = 0; wd_s1_done = 0; wd_s2_done = 0;
    d_lim[0] = 1000; d_lim[1] = 1000; d_lim[2] = 1000;
    clear_traffic();
    #2;
    n_chk++;
    if (obs_main() !== 33'h0) $display("FAIL reset_main got=%h exp=0", obs_main());
    else n_pass++;
    n_chk++;
    if (obs_wd() !== 33'h0) $display("FAIL reset_wd got=%h exp=0", obs_wd());
    else n_pass++;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;
    n_chk++;
    if (obs_main() !== 33'h0) $display("FAIL reset_idle got=%h exp=0", obs_main());
    else n_pass++;
    m_wb = 0; m_err = 0; m_ill = 0;
  endtask

  task automatic test_normal();
    run_sequence(1000, 33000, 2000, 1'b1, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_sequence(20, 30, 10, 1'b0, 1'b1);
  endtask

  task automatic test_mux();
    bit got;
    logic wb;
    d_lim[0] = 3; d_lim[1] = 40; d_lim[2] = 3;
    wb = 1'($urandom);
    @(posedge clk); #1 start = 1; cfg_wb = wb;
    @(posedge clk); #1 start = 0;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (s1_en) begin got = 1; break; end
    end
    n_chk++;
    if (!got) $display("FAIL mux_reach_run1 got=timeout exp=s1_en");
    else n_pass++;
    s1_wr = 1; s1_addr = 14'd129; s1_wdata = 1;
    #1;
    n_chk++;
    if ({mem_wr, mem_rd, mem_addr, mem_wdata} !== {1'b1, 1'b0, 14'd129, 8'hFF})
      $display("FAIL mux_wdata_ff got=%b/%b/%0d/%h exp=1/0/129/ff",
               mem_wr, mem_rd, mem_addr, mem_wdata);
    else n_pass++;
    s1_wdata = 0;
    #1;
    n_chk++;
    if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 14'd129, 8'h00})
      $display("FAIL mux_wdata_00 got=%b/%0d/%h exp=1/129/00", mem_wr, mem_addr, mem_wdata);
    else n_pass++;
    clear_traffic();
    got = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (all_done) begin got = 1; break; end
    end
    n_chk++;
    if (!got) $display("FAIL mux_all_done got=timeout exp=pulse");
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if ({busy, wb_flag, illegal_acc} !== {1'b0, wb, 1'b0})
      $display("FAIL mux_end_idle got=%b%b%b exp=0%b0", busy, wb_flag, illegal_acc, wb);
    else n_pass++;
    m_wb = wb; m_err = 0; m_ill = 0;
  endtask

  task automatic test_protocol();
    bit got;
    logic r;
    d_lim[0] = 30; d_lim[1] = 3; d_lim[2] = 3;
    @(posedge clk); #1 start = 1; cfg_wb = 1;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1;                       // first RUN0 cycle
    r = 1'($urandom);
    s2_rd = 1; s0_rd = r; s0_addr = 14'd77;
    #1;
    n_chk++;
    if ({s0_en, mem_rd, mem_wr, illegal_acc} !== {1'b1, r, 1'b0, 1'b0})
      $display("FAIL prot_inactive_rd got=%b%b%b%b exp=1%b00", s0_en, mem_rd, mem_wr,
               illegal_acc, r);
    else n_pass++;
    @(posedge clk); #1;
    s2_rd = 0; s0_rd = 1; s0_wr = 1;
    #1;
    n_chk++;
    if ({illegal_acc, mem_wr, mem_rd} !== 3'b110)
      $display("FAIL prot_rd_wr got=%b%b%b exp=110", illegal_acc, mem_wr, mem_rd);
    else n_pass++;
    clear_traffic();
    got = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (all_done) begin got = 1; break; end
    end
    n_chk++;
    if (!got || illegal_acc !== 1'b1)
      $display("FAIL prot_sticky got=done%0d/ill%b exp=done1/ill1", got, illegal_acc);
    else n_pass++;
    @(posedge clk); #1;
    m_wb = 1; m_err = 0; m_ill = 1;
  endtask

  task automatic test_watchdog();
    bit got;
    int cnt;
    wd_s0_done = 1; wd_s1_done = 0; wd_s2_done = 0;
    @(posedge clk); #1 start_w = 1; cfg_wb = 0;
    @(posedge clk); #1 start_w = 0;
    n_chk++;
    if ({wd_stg_rst, wd_busy, wd_err} !== 3'b110)
      $display("FAIL wdog_clr got=%b%b%b exp=110", wd_stg_rst, wd_busy, wd_err);
    else n_pass++;
    got = 0; cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (wd_err) begin got = 1; break; end
      if (wd_s1_en) cnt++;
    end
    n_chk++;
    if (!got || cnt != 100) $display("FAIL wdog_run1_len got=%0d err=%0d exp=100 err=1", cnt, got);
    else n_pass++;
    s1_wr = 1; s1_rd = 1; s0_rd = 1; s1_addr = 14'd5;
    #1;
    n_chk++;
    if ({wd_err, wd_s1_en, wd_busy, wd_mem_rd, wd_mem_wr} !== 5'b10000)
      $display("FAIL wdog_err_state got=%b%b%b%b%b exp=10000", wd_err, wd_s1_en, wd_busy,
               wd_mem_rd, wd_mem_wr);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({wd_err, wd_busy, wd_mem_wr} !== 3'b100)
      $display("FAIL wdog_err_sticky got=%b%b%b exp=100", wd_err, wd_busy, wd_mem_wr);
    else n_pass++;
    clear_traffic();
    start_w = 1; cfg_wb = 1;
    @(posedge clk); #1 start_w = 0;
    n_chk++;
    if ({wd_err, wd_stg_rst, wd_busy, wd_wb} !== 4'b0111)
      $display("FAIL wdog_restart got=%b%b%b%b exp=0111", wd_err, wd_stg_rst, wd_busy, wd_wb);
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if ({wd_s0_en, wd_stg_rst} !== 2'b10)
      $display("FAIL wdog_restart_run0 got=%b%b exp=10", wd_s0_en, wd_stg_rst);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    bit got;
    logic [ADDR_W-1:0] ad;
    d_lim[0] = 3; d_lim[1] = 3; d_lim[2] = 50;
    @(posedge clk); #1 start = 1; cfg_wb = 1;
    @(posedge clk); #1 start = 0;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (s2_en) begin got = 1; break; end
    end
    ad = 14'($urandom);
    s2_wr = 1; s2_addr = ad; s2_wdata = 8'($urandom);
    #1;
    n_chk++;
    if (!got || mem_wr !== 1'b1 || mem_addr !== ad)
      $display("FAIL rst_pre_wr got=run2:%0d wr:%b addr:%0d exp=1/1/%0d", got, mem_wr,
               mem_addr, ad);
    else n_pass++;
    #2 reset = 1;
    #1;
    n_chk++;
    if (obs_main() !== 33'h0) $display("FAIL rst_async got=%h exp=0", obs_main());
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if (obs_main() !== 33'h0) $display("FAIL rst_hold got=%h exp=0", obs_main());
    else n_pass++;
    reset = 0;
    clear_traffic();
    m_wb = 0; m_err = 0; m_ill = 0;
    run_sequence(5, 7, 4, 1'b1, 1'b0);
  endtask

  task automatic test_random_runs();
    run_sequence(0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      run_sequence($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40),
                   1'($urandom), 1'b0);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_mux();
    test_protocol();
    test_start_while_busy();
    test_watchdog();
    test_reset_mid_run();
    test_random_runs();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
